// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of an asynchronous clock (sig_in) in
// clk_in cycles, flags frequency lock and reports loss-of-signal timeouts.
// Optional feature macro: HIGH_TIME_MEASURE_EN adds high-time measurement;
// without it high_time is tied to zero and the port list is unchanged.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic             measuring,
  output logic [CNT_W-1:0] high_time
);

  localparam int               MW         = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TOL_V      = CNT_W'(TOL);
  localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_COUNT);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_s_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       diff;
  logic [MW-1:0]          match_cnt;
  logic [MW-1:0]          match_next;
  logic                   have_prev;

  assign sig_s     = sync_q[SYNC_STAGES-1];
  assign rise      = sig_s & ~sig_s_d;
  assign measuring = (state == MEAS);

  // Synchronize sig_in and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sig_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_s_d <= sig_s;
    end
  end

  // Next match count: compare the period about to be stored with the previous one.
  always_comb begin
    diff       = (cnt >= period) ? (cnt - period) : (period - cnt);
    match_next = '0;
    if (have_prev && (diff <= TOL_V)) begin
      match_next = (match_cnt == MATCH_FULL) ? MATCH_FULL : (match_cnt + MW'(1));
    end
  end

  // Measurement FSM: period counter, lock tracking and timeout, all registered.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      match_cnt    <= '0;
      have_prev    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        have_prev <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state     <= MEAS;
              cnt       <= CNT_W'(1);
              have_prev <= 1'b0;
            end
          end
          MEAS: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              cnt          <= CNT_W'(1);
              have_prev    <= 1'b1;
              match_cnt    <= match_next;
              locked       <= (match_next == MATCH_FULL);
            end else if (cnt == CNT_MAX) begin
              timeout   <= 1'b1;
              state     <= IDLE;
              cnt       <= '0;
              match_cnt <= '0;
              locked    <= 1'b0;
              have_prev <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HIGH_TIME_MEASURE_EN
  logic [CNT_W-1:0] hcnt;

  // High-time counter follows the same period boundaries as cnt; it never
  // exceeds cnt, so it cannot wrap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      high_time <= '0;
    end else if (!en) begin
      hcnt <= '0;
    end else if (state == IDLE) begin
      hcnt <= rise ? CNT_W'(sig_s) : '0;
    end else if (rise) begin
      high_time <= hcnt;
      hcnt      <= CNT_W'(sig_s);
    end else if (cnt == CNT_MAX) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + CNT_W'(sig_s);
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: the stimulus process plans sig_in
// periods, derives expected results from period lengths and pushes them;
// a monitor pops and compares whenever the DUT pulses period_valid/timeout.
module tb_clk_period_meter;

  localparam int CW   = 8;
  localparam int LC   = 4;
  localparam int TL   = 1;
  localparam int MAXP = (1 << CW) - 1;
`ifdef HIGH_TIME_MEASURE_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic          measuring;

  clk_period_meter #(
    .CNT_W(CW),
    .SYNC_STAGES(2),
    .LOCK_COUNT(LC),
    .TOL(TL)
  ) dut (
    .clk_in(clk),
    .rst_n(rst_n),
    .en(en),
    .sig_in(sig_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .measuring(measuring),
    .high_time(high_time)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    bit lck;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   total = 0;
  int   bad = 0;
  int   last_period = 0;
  bit   open = 1'b0;
  int   prev_p = 0;
  int   prev_h = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Locked when the last LC results since idle each lie within TL of their predecessor.
  function automatic bit model_locked();
    if (hist.size() < LC + 1) return 1'b0;
    for (int j = hist.size() - LC; j < hist.size(); j++) begin
      int d;
      d = hist[j] - hist[j-1];
      if (d < 0) d = -d;
      if (d > TL) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_valid(input int p, input int h);
    exp_t e;
    hist.push_back(p);
    e.is_to = 1'b0;
    e.per   = p;
    e.hi    = HT ? h : 0;
    e.lck   = model_locked();
    last_period = p;
    sb.push_back(e);
  endtask

  task automatic push_timeout();
    exp_t e;
    e.is_to = 1'b1;
    e.per   = last_period;
    e.hi    = 0;
    e.lck   = 1'b0;
    sb.push_back(e);
    hist.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_measuring"}, measuring, 0);
    chk({tag, "_high_time"}, high_time, 0);
  endtask

  // One sig_in period starting at a negedge: h cycles high, then low.
  // abort=1 drops en mid-low, abort=2 pulses rst_n mid-low.
  task automatic drive_period(input int h, input int l, input int abort);
    sig_in = 1'b1;
    if (open) push_valid(prev_p, prev_h);
    open = 1'b1;
    if (abort == 0 && h + l > MAXP) begin
      push_timeout();
      open = 1'b0;
    end
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    if (abort == 0) begin
      repeat (l) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
      if (abort == 1) begin
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_low_locked", locked, 0);
        chk("en_low_measuring", measuring, 0);
        chk("en_low_period_hold", period, last_period);
        repeat (45) @(negedge clk);
        en = 1'b1;
      end else begin
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(negedge clk);
        check_zero("rst_held");
        rst_n = 1'b1;
        last_period = 0;
      end
      repeat (10) @(negedge clk);
      open = 1'b0;
      hist.delete();
    end
    prev_p = h + l;
    prev_h = h;
  endtask

  // Monitor: pop one expectation per output pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && (period_valid === 1'b1 || timeout === 1'b1)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {period_valid, timeout}, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_is_timeout", timeout, e.is_to);
          chk("pulse_is_valid", period_valid, !e.is_to);
          chk("period", period, e.per);
          chk("locked", locked, e.lck);
          chk("measuring", measuring, !e.is_to);
          if (!e.is_to) chk("high_time", high_time, e.hi);
        end
      end
    end
  end

  int tol_tab[4] = '{20, 21, 20, 19};

  initial begin
    int base;
    int p;
    int h;
    rst_n  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Steady 20-cycle clock, 7 high: lock on the 5th result.
    for (int i = 0; i < 8; i++) drive_period(7, 13, 0);
    // Jitter within tolerance, then a step to 30 and relock.
    for (int i = 0; i < 4; i++) drive_period(7, tol_tab[i] - 7, 0);
    for (int i = 0; i < 6; i++) drive_period(10, 20, 0);
    // Enable dropped while locked, then relock.
    for (int i = 0; i < 6; i++) drive_period(7, 13, 0);
    drive_period(7, 0, 1);
    for (int i = 0; i < 7; i++) drive_period(7, 13, 0);
    // Reset mid-period while locked, then relock.
    drive_period(7, 0, 2);
    for (int i = 0; i < 7; i++) drive_period(7, 13, 0);
    // Largest measurable period, then a gap long enough to time out.
    drive_period(10, MAXP - 10, 0);
    drive_period(10, 300, 0);
    for (int i = 0; i < 3; i++) drive_period(7, 13, 0);
    // Random periods with occasional frequency steps.
    base = 20;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) base = $urandom_range(6, 120);
      p = base + $urandom_range(0, 2) - 1;
      h = $urandom_range(1, p - 2);
      drive_period(h, p - h, 0);
    end

    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
